// File: rtl/ws2811_transmitter_if.sv
// Pixel-source and strip-side signals of the WS2811 frame transmitter.
interface ws2811_transmitter_if;
  logic       enable;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic [7:0] ledindex;
  logic       data_out;
  logic       busy;
  logic       frame_done;

  modport master (
    output enable, red, green, blue,
    input  ledindex, data_out, busy, frame_done
  );

  modport slave (
    input  enable, red, green, blue,
    output ledindex, data_out, busy, frame_done
  );
endinterface

// File: rtl/ws2811_transmitter.sv
// WS2811 frame master: fetches pixels by ledindex, serializes them back to back
// onto the one-wire line, then holds a low latch gap and pulses frame_done.
module ws2811_transmitter #(
  parameter int NUM_LEDS   = 49,
  parameter int BIT_CYC    = 62,
  parameter int T0H_CYC    = 20,
  parameter int T1H_CYC    = 40,
  parameter int RESET_CYC  = 3000,
  parameter int LOOKUP_LAT = 2,
  parameter int GRB_ORDER  = 1
) (
  input logic                  clk,
  input logic                  rst,
  ws2811_transmitter_if.slave  bus
);

  localparam int CMAX1   = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int CMAX    = (CMAX1 > LOOKUP_LAT + 2) ? CMAX1 : LOOKUP_LAT + 2;
  localparam int CW      = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] RST_LAST   = CW'(RESET_CYC - 1);
  localparam logic [CW-1:0] FETCH_LAST = CW'(LOOKUP_LAT);
  localparam logic [CW-1:0] CAP_CYC    = CW'(LOOKUP_LAT + 1);
  localparam logic [CW-1:0] T0H        = CW'(T0H_CYC);
  localparam logic [CW-1:0] T1H        = CW'(T1H_CYC);
  localparam logic [7:0]    LAST_LED   = 8'(NUM_LEDS - 1);

  generate
    if (NUM_LEDS < 1 || NUM_LEDS > 256 || BIT_CYC <= LOOKUP_LAT + 2 ||
        T1H_CYC >= BIT_CYC || T0H_CYC < 1 || T0H_CYC > T1H_CYC || RESET_CYC < 1) begin : g_bad_param
      $error("ws2811_transmitter: illegal timing parameters");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [4:0]     bit_idx, bit_n;
  logic [7:0]     led, led_n;
  logic [23:0]    shift, shift_n;
  logic [23:0]    next_pix, npix_n;
  logic [7:0]     idx_q, idx_n;
  logic           data_q, data_n;
  logic           busy_q, busy_n;
  logic           done_q, done_n;
  logic [23:0]    pix;

  assign pix = (GRB_ORDER != 0) ? {bus.green, bus.red, bus.blue}
                                : {bus.red, bus.green, bus.blue};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      led      <= '0;
      shift    <= '0;
      next_pix <= '0;
      idx_q    <= '0;
      data_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      led      <= led_n;
      shift    <= shift_n;
      next_pix <= npix_n;
      idx_q    <= idx_n;
      data_q   <= data_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    led_n   = led;
    shift_n = shift;
    npix_n  = next_pix;
    idx_n   = idx_q;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_n = FETCH;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      FETCH: begin
        if (cnt == FETCH_LAST) begin
          state_n = SEND;
          cnt_n   = '0;
          bit_n   = '0;
          led_n   = '0;
          shift_n = pix;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      SEND: begin
        // Next LED is requested at the start of bit 0 so its pixel is ready
        // long before the current LED's last bit ends.
        if (bit_idx == 5'd0 && led != LAST_LED) begin
          if (cnt == '0)     idx_n  = led + 8'd1;
          if (cnt == CAP_CYC) npix_n = pix;
        end
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {shift[22:0], 1'b0};
          bit_n   = bit_idx + 5'd1;
          if (bit_idx == 5'd23) begin
            bit_n = '0;
            if (led == LAST_LED) begin
              state_n = LATCH;
            end else begin
              led_n   = led + 8'd1;
              shift_n = next_pix;
            end
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      LATCH: begin
        if (cnt == RST_LAST) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = bus.enable ? FETCH : IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the strip pin is glitch-free.
  always_comb begin
    data_n = (state_n == SEND) && (cnt_n < (shift_n[23] ? T1H : T0H));
    busy_n = (state_n != IDLE);
    done_n = (state_n == LATCH) && (cnt_n == RST_LAST);
  end

  assign bus.ledindex   = idx_q;
  assign bus.data_out   = data_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule
